// File: rtl/tcb_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tcb_frame_feeder
// Brief    : Packs a 121-beat AXI-Stream byte image for the TCB classifier
//            core, starts it, waits for done and returns the class as a
//            single-beat stream. Optional macro TCB_FEEDER_TLAST_CHECK_EN
//            discards frames whose tlast does not line up with beat 120.
// Revision : 1.0 - initial release
// ============================================================================
module tcb_frame_feeder #(
    parameter int N_PIX = 121,
    parameter int PIX_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PIX_W-1:0]         s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic [N_PIX*PIX_W-1:0]   img_source,
    output logic                     valid_top,
    input  logic                     ready_top,
    input  logic [7:0]               number,
    output logic [7:0]               m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic                     frame_err
);

    localparam int               c_cnt_w     = $clog2(N_PIX);
    localparam logic [c_cnt_w-1:0] c_last_slot = c_cnt_w'(N_PIX - 1);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_FIRE = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_SEND = 2'd3;

    logic [1:0]               r_state;
    logic [1:0]               w_next;
    logic [c_cnt_w-1:0]       r_cnt;
    logic [N_PIX*PIX_W-1:0]   r_img;
    logic                     r_valid_top;
    logic [7:0]               r_m_tdata;
    logic                     r_m_tvalid;
    logic                     w_accept;
    logic                     w_last_slot;
    logic                     w_cnt_clear;

    assign w_accept    = s_axis_tvalid && s_axis_tready;
    assign w_last_slot = (r_cnt == c_last_slot);

`ifdef TCB_FEEDER_TLAST_CHECK_EN
    logic w_discard;
    logic r_frame_err;

    // A frame is good only when tlast and the final slot coincide.
    assign w_discard   = w_accept && (w_last_slot != s_axis_tlast);
    assign w_cnt_clear = w_last_slot || s_axis_tlast;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_discard;
        end
    end

    assign frame_err = r_frame_err;
`else
    assign w_cnt_clear = w_last_slot;
    // tlast carries no meaning in this build; ANDing with zero keeps it referenced.
    assign frame_err   = s_axis_tlast & 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD: begin
`ifdef TCB_FEEDER_TLAST_CHECK_EN
                if (w_accept && w_last_slot && !w_discard) begin
                    w_next = S_FIRE;
                end
`else
                if (w_accept && w_last_slot) begin
                    w_next = S_FIRE;
                end
`endif
            end
            S_FIRE:  w_next = S_WAIT;
            S_WAIT:  if (ready_top) w_next = S_SEND;
            S_SEND:  if (m_axis_tready) w_next = S_LOAD;
            default: w_next = S_LOAD;
        endcase
    end

    // Only input-side handshake is combinational; rst gating keeps it low in reset.
    always_comb begin
        s_axis_tready = 1'b0;
        if (rst && (r_state == S_LOAD)) begin
            s_axis_tready = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_img       <= '0;
            r_valid_top <= 1'b0;
            r_m_tdata   <= 8'h00;
            r_m_tvalid  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_img[int'(r_cnt) * PIX_W +: PIX_W] <= s_axis_tdata;
                r_cnt <= w_cnt_clear ? '0 : r_cnt + 1'b1;
            end
            r_valid_top <= (w_next == S_FIRE);
            r_m_tvalid  <= (w_next == S_SEND);
            if ((r_state == S_WAIT) && ready_top) begin
                r_m_tdata <= number;
            end
        end
    end

    assign img_source    = r_img;
    assign valid_top     = r_valid_top;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tvalid;

endmodule
`default_nettype wire

// File: tb/tb_tcb_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcb_frame_feeder
// Brief    : Directed bench for tcb_frame_feeder; define
//            TCB_FEEDER_TLAST_CHECK_EN to also exercise frame discard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tcb_frame_feeder;

    localparam int N_PIX = 121;
    localparam int PIX_W = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [PIX_W-1:0]       s_axis_tdata = '0;
    logic                   s_axis_tvalid = 1'b0;
    logic                   s_axis_tlast = 1'b0;
    logic                   s_axis_tready;
    logic [N_PIX*PIX_W-1:0] img_source;
    logic                   valid_top;
    logic                   ready_top = 1'b0;
    logic [7:0]             number = 8'h00;
    logic [7:0]             m_axis_tdata;
    logic                   m_axis_tvalid;
    logic                   m_axis_tlast;
    logic                   m_axis_tready = 1'b0;
    logic                   frame_err;

    logic [N_PIX*PIX_W-1:0] exp_img = '0;
    int checks = 0;
    int errors = 0;
    int vt_count = 0;
    int fe_count = 0;
    int vt_before;
    int fe_before;

    tcb_frame_feeder #(.N_PIX(N_PIX), .PIX_W(PIX_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .img_source    (img_source),
        .valid_top     (valid_top),
        .ready_top     (ready_top),
        .number        (number),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_top === 1'b1) vt_count++;
        if (frame_err === 1'b1) fe_count++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns at posedge+1 right after the last beat was accepted.
    task automatic send_frame(input int base, input bit bubbly, input int n_beats,
                              input int tlast_idx);
        for (int k = 0; k < n_beats; k++) begin
            int guard;
            logic [7:0] b;
            if (bubbly) begin
                s_axis_tvalid = 1'b0;
                tick(1);
            end
            b = 8'(base + k);
            s_axis_tdata  = b;
            s_axis_tlast  = (k == tlast_idx);
            s_axis_tvalid = 1'b1;
            guard = 0;
            while (!s_axis_tready && guard < 200) begin
                tick(1);
                guard++;
            end
            if (guard >= 200) begin
                checks++;
                errors++;
                $display("FAIL beat_accept: beat %0d tready stuck at %b, need 1", k, s_axis_tready);
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                return;
            end
            exp_img[k*PIX_W +: PIX_W] = b;
            tick(1);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick(2);
        checks++;
        if (s_axis_tready !== 1'b0) begin
            errors++; $display("FAIL rst_tready_low: got %b need 0", s_axis_tready);
        end
        rst = 1'b1;
        tick(1);
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL reset_tready: got %b need 1", s_axis_tready);
        end
        checks++;
        if ({valid_top, m_axis_tvalid, m_axis_tlast, frame_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b need 0000",
                               {valid_top, m_axis_tvalid, m_axis_tlast, frame_err});
        end
        checks++;
        if (m_axis_tdata !== 8'h00) begin
            errors++; $display("FAIL reset_tdata: got %h need 00", m_axis_tdata);
        end
        checks++;
        if (img_source !== '0) begin
            errors++; $display("FAIL reset_img: got nonzero image, need all zero");
        end
    endtask

    task automatic test_nominal;
        vt_before = vt_count;
        send_frame(0, 1'b0, N_PIX, N_PIX-1);
        checks++;
        if (valid_top !== 1'b1 || s_axis_tready !== 1'b0) begin
            errors++; $display("FAIL nom_fire: valid_top=%b tready=%b need 1 0", valid_top, s_axis_tready);
        end
        checks++;
        if (img_source[7:0] !== 8'h00 || img_source[967:960] !== 8'h78) begin
            errors++; $display("FAIL nom_ends: got %h/%h need 00/78", img_source[7:0], img_source[967:960]);
        end
        checks++;
        if (img_source !== exp_img) begin
            errors++; $display("FAIL nom_image: packed image differs from expected");
        end
        tick(1);
        checks++;
        if (valid_top !== 1'b0) begin
            errors++; $display("FAIL nom_fire_width: valid_top=%b need 0", valid_top);
        end
        tick(49);
        checks++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || vt_count - vt_before != 1) begin
            errors++; $display("FAIL nom_wait: tready=%b tvalid=%b pulses=%0d need 0 0 1",
                               s_axis_tready, m_axis_tvalid, vt_count - vt_before);
        end
        number = 8'h07; ready_top = 1'b1;
        tick(1);
        ready_top = 1'b0; number = 8'hFF;
        checks++;
        if (m_axis_tdata !== 8'h07 || m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1) begin
            errors++; $display("FAIL nom_result: data=%h valid=%b last=%b need 07 1 1",
                               m_axis_tdata, m_axis_tvalid, m_axis_tlast);
        end
    endtask

    task automatic test_backpressure;
        int bad = 0;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (m_axis_tdata !== 8'h07 || m_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL bp_hold: %0d bad cycles, need 0 (data=%h)", bad, m_axis_tdata);
        end
        m_axis_tready = 1'b1;
        tick(1);
        m_axis_tready = 1'b0;
        checks++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            errors++; $display("FAIL bp_release: tready=%b tvalid=%b need 1 0", s_axis_tready, m_axis_tvalid);
        end
    endtask

    task automatic test_bubbly;
        vt_before = vt_count;
        send_frame(8'h80, 1'b1, N_PIX, N_PIX-1);
        tick(3);
        checks++;
        if (img_source !== exp_img) begin
            errors++; $display("FAIL bub_image: packed image differs, byte0=%h need 80", img_source[7:0]);
        end
        checks++;
        if (vt_count - vt_before != 1) begin
            errors++; $display("FAIL bub_pulses: got %0d valid_top pulses need 1", vt_count - vt_before);
        end
        number = 8'h3C; ready_top = 1'b1;
        tick(1);
        ready_top = 1'b0;
        checks++;
        if (m_axis_tdata !== 8'h3C || m_axis_tvalid !== 1'b1) begin
            errors++; $display("FAIL bub_result: data=%h valid=%b need 3c 1", m_axis_tdata, m_axis_tvalid);
        end
        m_axis_tready = 1'b1;
        tick(1);
        m_axis_tready = 1'b0;
    endtask

    task automatic test_stray_ready;
        number = 8'h55; ready_top = 1'b1;
        tick(1);
        ready_top = 1'b0;
        tick(1);
        checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL stray_load: tvalid=%b tready=%b need 0 1", m_axis_tvalid, s_axis_tready);
        end
        send_frame(8'h10, 1'b0, N_PIX, N_PIX-1);
        number = 8'hEE; ready_top = 1'b1;
        tick(1);
        ready_top = 1'b0;
        tick(3);
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            errors++; $display("FAIL stray_fire: tvalid=%b need 0", m_axis_tvalid);
        end
        number = 8'h99; ready_top = 1'b1;
        tick(1);
        ready_top = 1'b0;
        checks++;
        if (m_axis_tdata !== 8'h99 || m_axis_tvalid !== 1'b1) begin
            errors++; $display("FAIL stray_genuine: data=%h valid=%b need 99 1", m_axis_tdata, m_axis_tvalid);
        end
        m_axis_tready = 1'b1;
        tick(1);
        m_axis_tready = 1'b0;
    endtask

    task automatic test_reset_wait;
        send_frame(8'h40, 1'b0, N_PIX, N_PIX-1);
        tick(5);
        rst = 1'b0;
        #1;
        exp_img = '0;
        checks++;
        if ({s_axis_tready, valid_top, m_axis_tvalid, m_axis_tlast, frame_err} !== 5'b0 ||
            m_axis_tdata !== 8'h00 || img_source !== '0) begin
            errors++; $display("FAIL rstw_outputs: flags=%b data=%h need 00000 00",
                               {s_axis_tready, valid_top, m_axis_tvalid, m_axis_tlast, frame_err}, m_axis_tdata);
        end
        tick(3);
        rst = 1'b1;
        number = 8'h11; ready_top = 1'b1;
        tick(1);
        ready_top = 1'b0;
        tick(1);
        checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL rstw_ignore: tvalid=%b tready=%b need 0 1", m_axis_tvalid, s_axis_tready);
        end
        send_frame(8'h20, 1'b0, N_PIX, N_PIX-1);
        checks++;
        if (img_source !== exp_img || valid_top !== 1'b1) begin
            errors++; $display("FAIL rstw_frame: byte0=%h valid_top=%b need 20 1", img_source[7:0], valid_top);
        end
        tick(2);
        number = 8'h42; ready_top = 1'b1;
        tick(1);
        ready_top = 1'b0;
        checks++;
        if (m_axis_tdata !== 8'h42 || m_axis_tvalid !== 1'b1) begin
            errors++; $display("FAIL rstw_result: data=%h valid=%b need 42 1", m_axis_tdata, m_axis_tvalid);
        end
        m_axis_tready = 1'b1;
        tick(1);
        m_axis_tready = 1'b0;
    endtask

`ifdef TCB_FEEDER_TLAST_CHECK_EN
    task automatic test_tlast_err;
        vt_before = vt_count;
        fe_before = fe_count;
        send_frame(8'hA0, 1'b0, 60, 59);
        checks++;
        if (frame_err !== 1'b1 || s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL tl_err_pulse: frame_err=%b tready=%b need 1 1", frame_err, s_axis_tready);
        end
        tick(1);
        checks++;
        if (frame_err !== 1'b0 || fe_count - fe_before != 1 || vt_count != vt_before) begin
            errors++; $display("FAIL tl_err_once: frame_err=%b pulses=%0d fires=%0d need 0 1 0",
                               frame_err, fe_count - fe_before, vt_count - vt_before);
        end
        checks++;
        if (img_source !== exp_img) begin
            errors++; $display("FAIL tl_partial: slot59=%h need %h", img_source[59*8 +: 8], exp_img[59*8 +: 8]);
        end
        send_frame(8'h05, 1'b0, N_PIX, N_PIX-1);
        checks++;
        if (valid_top !== 1'b1 || img_source !== exp_img) begin
            errors++; $display("FAIL tl_good: valid_top=%b byte0=%h need 1 05", valid_top, img_source[7:0]);
        end
        tick(2);
        number = 8'h09; ready_top = 1'b1;
        tick(1);
        ready_top = 1'b0;
        checks++;
        if (m_axis_tdata !== 8'h09 || m_axis_tvalid !== 1'b1) begin
            errors++; $display("FAIL tl_result: data=%h valid=%b need 09 1", m_axis_tdata, m_axis_tvalid);
        end
        m_axis_tready = 1'b1;
        tick(1);
        m_axis_tready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_bubbly();
        test_stray_ready();
        test_reset_wait();
`ifdef TCB_FEEDER_TLAST_CHECK_EN
        test_tlast_err();
`else
        checks++;
        if (fe_count != 0) begin
            errors++; $display("FAIL err_tied: frame_err pulsed %0d times need 0", fe_count);
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
